// File: rtl/uart8_receiver_pkg.sv
// Shared UART definitions: frame state encoding, data width, default oversampling.
// The state enum is common to the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_W         = 8;
    localparam int DEF_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4
    } uart_state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart8_receiver_if.sv
// Receiver line/result bundle: enable and serial line in, byte and status out.
// master drives the line side, slave is the receiver.
interface uart8_receiver_if;
    import uart_pkg::*;

    logic              en;
    logic              in;
    logic [DATA_W-1:0] out;
    logic              done;
    logic              busy;
    logic              err;

    modport master (
        output en,
        output in,
        input  out,
        input  done,
        input  busy,
        input  err
    );

    modport slave (
        input  en,
        input  in,
        output out,
        output done,
        output busy,
        output err
    );

endinterface

// File: rtl/uart8_receiver_sync.sv
// Two-flop synchronizer for the async rx line plus falling-edge detect.
// All flops reset to the idle level (1) so reset never fakes an edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rx_s,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= in;
            rx_s <= meta;
            prev <= rx_s;
        end
    end

    assign fall = prev & ~rx_s;

endmodule

// File: rtl/uart8_receiver.sv
// Oversampling 8-bit UART receiver, 8N1 by default.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop.
module uart8_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input logic         clk,
    input logic         rst,
    uart8_receiver_if.slave rx
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    uart_state_t       state;
    logic [CW-1:0]     cnt;
    logic [2:0]        idx;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] out_q;
    logic              done_q;
    logic              busy_q;
    logic              err_q;
    logic              rx_s;
    logic              fall;
`ifdef UART_RX_PARITY_EN
    logic              par_err;
`endif

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .in   (rx.in),
        .rx_s (rx_s),
        .fall (fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err <= 1'b0;
`endif
        end else if (state != IDLE && !rx.en) begin
            // abort: drop the partial frame, keep the last result
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    idx    <= '0;
                    busy_q <= 1'b0;
                    if (rx.en && fall) begin
                        state  <= START_BIT;
                        busy_q <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA_BITS;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                DATA_BITS: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[DATA_W-1:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY_BIT;
`else
                            state <= STOP_BIT;
`endif
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY_BIT: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        par_err <= rx_s ^ even_parity(shift);
                        state   <= STOP_BIT;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
`endif
                STOP_BIT: begin
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        out_q  <= shift;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        err_q  <= ~rx_s | par_err;
`else
                        err_q  <= ~rx_s;
`endif
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    idx    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx.out  = out_q;
    assign rx.done = done_q;
    assign rx.busy = busy_q;
    assign rx.err  = err_q;

endmodule

// File: tb/tb_uart8_receiver.sv
// Directed + randomized bench for uart8_receiver against a frame-level model.
// Build with UART_RX_PARITY_EN defined to cover the parity variant.
module tb_uart8_receiver;
    import uart_pkg::*;

    localparam int OS = 16;
    localparam int H  = OS / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // done edge offset from E0; E0 is 3 edges after the start bit is driven
    localparam int DOFF = OS / 2 + (NB - 1) * OS;
    localparam int E0K  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] exp_out = 8'h00;
    logic       exp_err = 1'b0;
    logic [7:0] rd;
    logic       rs;
    logic       rp;

    uart8_receiver_if ifc ();

    uart8_receiver #(.OVERSAMPLE(OS)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // kind: 0 = full frame, 1 = rst at step ka, 2 = en low at step ka
    task automatic run_frame(input logic [7:0] d, input logic stopv,
                             input logic parv, input int ka,
                             input int kind);
        logic fr [NB];
        bit   aborted;
        int   kk;
        aborted = 1'b0;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[i+1] = d[i];
`ifdef UART_RX_PARITY_EN
        fr[9] = parv;
`endif
        fr[NB-1] = stopv;
        for (int k = 0; k < NB * OS; k++) begin
            if (k == ka) begin
                aborted = 1'b1;
                if (kind == 1) rst = 1'b1;
                else ifc.en = 1'b0;
            end
            ifc.in = aborted ? 1'b1 : fr[k / OS];
            @(posedge clk);
            #1;
            rst = 1'b0;
            ifc.en = 1'b1;
            kk = k + 1;
            if (aborted) begin
                chk("abort_busy", {7'd0, ifc.busy}, 8'd0);
                chk("abort_done", {7'd0, ifc.done}, 8'd0);
                if (kk == ka + 1) begin
                    if (kind == 1) begin
                        exp_out = 8'h00;
                        exp_err = 1'b0;
                    end
                    chk("abort_out", ifc.out, exp_out);
                    chk("abort_err", {7'd0, ifc.err}, {7'd0, exp_err});
                end
            end else begin
                chk("busy", {7'd0, ifc.busy},
                    {7'd0, (kk >= E0K && kk < E0K + DOFF)});
                chk("done", {7'd0, ifc.done},
                    {7'd0, (kk == E0K + DOFF)});
                if (kk == E0K + DOFF) begin
                    exp_out = d;
                    exp_err = ~stopv;
`ifdef UART_RX_PARITY_EN
                    if (parv != ^d) exp_err = 1'b1;
`endif
                    chk("out", ifc.out, exp_out);
                    chk("err", {7'd0, ifc.err}, {7'd0, exp_err});
                end
            end
        end
        chk("out_hold", ifc.out, exp_out);
        chk("err_hold", {7'd0, ifc.err}, {7'd0, exp_err});
    endtask

    task automatic hold(input int n, input logic v);
        for (int k = 0; k < n; k++) begin
            ifc.in = v;
            @(posedge clk);
            #1;
            chk("hold_busy", {7'd0, ifc.busy}, 8'd0);
            chk("hold_done", {7'd0, ifc.done}, 8'd0);
        end
    endtask

    task automatic glitch();
        int bc;
        bc = 0;
        for (int k = 0; k < 48; k++) begin
            ifc.in = (k < 4) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (ifc.busy) bc++;
            chk("glitch_done", {7'd0, ifc.done}, 8'd0);
        end
        checks++;
        assert (bc >= 1 && bc <= H) else begin
            errors++;
            $error("FAIL glitch_busy: got %0d cycles want 1..%0d", bc, H);
        end
        chk("glitch_idle", {7'd0, ifc.busy}, 8'd0);
        chk("glitch_out", ifc.out, exp_out);
    endtask

    initial begin
        ifc.en = 1'b1;
        ifc.in = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", ifc.out, 8'h00);
        chk("rst_done", {7'd0, ifc.done}, 8'd0);
        chk("rst_busy", {7'd0, ifc.busy}, 8'd0);
        chk("rst_err", {7'd0, ifc.err}, 8'd0);
        rst = 1'b0;
        hold(5, 1'b1);

        run_frame(8'hA5, 1'b1, ^8'hA5, -1, 0);
        hold(10, 1'b1);
        glitch();

        run_frame(8'h3C, 1'b0, ^8'h3C, -1, 0);
        hold(40, 1'b0);
        hold(20, 1'b1);
        run_frame(8'h11, 1'b1, ^8'h11, -1, 0);

        run_frame(8'h00, 1'b1, 1'b0, -1, 0);
        run_frame(8'hFF, 1'b1, 1'b0, -1, 0);
        hold(10, 1'b1);

        run_frame(8'hF0, 1'b1, 1'b0, 88, 1);
        hold(200, 1'b1);
        run_frame(8'h5A, 1'b1, 1'b0, -1, 0);
        run_frame(8'hC3, 1'b1, 1'b0, 56, 2);
        hold(20, 1'b1);

`ifdef UART_RX_PARITY_EN
        run_frame(8'h07, 1'b1, 1'b1, -1, 0);
        run_frame(8'h07, 1'b1, 1'b0, -1, 0);
        hold(10, 1'b1);
`endif

        for (int n = 0; n < 10; n++) begin
            rd = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            rp = (^rd) ^ ($urandom_range(0, 3) == 0);
            run_frame(rd, rs, rp, -1, 0);
            if (!rs) hold(20, 1'b1);
        end
        hold(10, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
